// File: rtl/rx_slot_if.sv
// Bundle between the RX slot scheduler and its receiver/host clients.
// The client side (receiver + host) is the master; the scheduler is the slave.
interface rx_slot_if #(
  parameter int SLOT_BITS = 2
);
  logic                 enable;
  logic                 rx_complete;
  logic [11:0]          rx_frame_len;
  logic [31:0]          rx_timestamp;
  logic                 rx_empty;
  logic [SLOT_BITS-1:0] wr_slot;
  logic                 host_valid;
  logic [SLOT_BITS-1:0] host_slot;
  logic [11:0]          host_len;
  logic [31:0]          host_ts;
  logic                 host_release;
  logic [SLOT_BITS:0]   occupancy;
  logic [15:0]          drop_cnt;

  // Handshakes: rx_complete is accepted only in a cycle where rx_empty=1,
  // otherwise it is dropped and counted; host_release retires the slot shown
  // on host_* only when host_valid=1 and is ignored otherwise. Both pulses are
  // single-cycle and never stall.
  modport master (
    output enable, rx_complete, rx_frame_len, rx_timestamp, host_release,
    input  rx_empty, wr_slot, host_valid, host_slot, host_len, host_ts,
           occupancy, drop_cnt
  );

  modport slave (
    input  enable, rx_complete, rx_frame_len, rx_timestamp, host_release,
    output rx_empty, wr_slot, host_valid, host_slot, host_len, host_ts,
           occupancy, drop_cnt
  );
endinterface

// File: rtl/rx_slot_sched.sv
// Ring of RX frame slots: arms a free slot for the receiver, enforces an
// inter-frame gap, and presents the oldest filled slot to the host.
module rx_slot_sched #(
  parameter int SLOT_BITS = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic       pci_clk,
  input  logic       sys_rst_n,
  rx_slot_if.slave   bus,
  output logic [1:0] state_dbg
);
  localparam int SLOTS = 1 << SLOT_BITS;
  localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]      GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [SLOT_BITS:0] OCC_FULL = (SLOT_BITS + 1)'(SLOTS);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [GW-1:0]        gap_cnt, gap_nxt;
  logic [SLOT_BITS:0]   wr_ptr, rd_ptr, occ;
  logic [15:0]          drop_cnt;
  logic                 rx_empty_q;
  logic                 full, accept, reject, release_ok;
  logic [11:0]          len_mem [SLOTS];
  logic [31:0]          ts_mem  [SLOTS];

  assign occ        = wr_ptr - rd_ptr;
  assign full       = (occ == OCC_FULL);
  assign accept     = bus.rx_complete && (state == ST_ARM);
  assign reject     = bus.rx_complete && (state != ST_ARM);
  assign release_ok = bus.host_release && (occ != '0);

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      ST_OFF: begin
        if (bus.enable) state_nxt = full ? ST_FULL : ST_ARM;
      end
      ST_ARM: begin
        // An accept wins over a same-cycle enable drop; the gap still runs.
        if (accept) begin
          state_nxt = ST_GAP;
          gap_nxt   = GAP_LOAD;
        end else if (!bus.enable) begin
          state_nxt = ST_OFF;
        end
      end
      ST_GAP: begin
        if (gap_cnt != '0)    gap_nxt   = gap_cnt - GW'(1);
        else if (!bus.enable) state_nxt = ST_OFF;
        else if (full)        state_nxt = ST_FULL;
        else                  state_nxt = ST_ARM;
      end
      ST_FULL: begin
        if (!bus.enable) state_nxt = ST_OFF;
        else if (!full)  state_nxt = ST_ARM;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_OFF;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      rx_empty_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      rx_empty_q <= (state_nxt == ST_ARM);
      if (accept)     wr_ptr <= wr_ptr + 1'b1;
      if (release_ok) rd_ptr <= rd_ptr + 1'b1;
      if (reject && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Slot payload is qualified by host_valid, so it carries no reset.
  always_ff @(posedge pci_clk) begin
    if (accept) begin
      len_mem[wr_ptr[SLOT_BITS-1:0]] <= bus.rx_frame_len;
      ts_mem[wr_ptr[SLOT_BITS-1:0]]  <= bus.rx_timestamp;
    end
  end

  assign bus.rx_empty   = rx_empty_q;
  assign bus.wr_slot    = wr_ptr[SLOT_BITS-1:0];
  assign bus.host_slot  = rd_ptr[SLOT_BITS-1:0];
  assign bus.host_valid = (occ != '0);
  assign bus.host_len   = len_mem[rd_ptr[SLOT_BITS-1:0]];
  assign bus.host_ts    = ts_mem[rd_ptr[SLOT_BITS-1:0]];
  assign bus.occupancy  = occ;
  assign bus.drop_cnt   = drop_cnt;
  assign state_dbg      = state;
endmodule

// File: tb/tb_rx_slot_sched.sv
// Directed bench for rx_slot_sched: arm/gap timing, fill and drop, wrap,
// simultaneous accept/release, and asynchronous reset.
module tb_rx_slot_sched;
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  logic       pci_clk;
  logic       sys_rst_n;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_fail;
  logic [43:0] exp_q[$];
  logic [43:0] exp_e;

  rx_slot_if #(.SLOT_BITS(2)) ifc ();

  rx_slot_sched #(.SLOT_BITS(2), .GAP_CYC(4)) dut (
    .pci_clk   (pci_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (ifc.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial pci_clk = 1'b0;
  always #5 pci_clk = ~pci_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge pci_clk);
    #1;
  endtask

  task automatic pulse_complete(input logic [11:0] len, input logic [31:0] ts);
    ifc.rx_complete  = 1'b1;
    ifc.rx_frame_len = len;
    ifc.rx_timestamp = ts;
    step();
    ifc.rx_complete  = 1'b0;
  endtask

  task automatic pulse_release();
    ifc.host_release = 1'b1;
    step();
    ifc.host_release = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!ifc.rx_empty && n < 20) begin
      step();
      n++;
    end
    check(tag, ifc.rx_empty, 1);
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ifc.enable       = 1'b0;
    ifc.rx_complete  = 1'b0;
    ifc.rx_frame_len = '0;
    ifc.rx_timestamp = '0;
    ifc.host_release = 1'b0;
    #1;
    apply_reset();

    // reset state
    check("rst_empty", ifc.rx_empty, 0);
    check("rst_valid", ifc.host_valid, 0);
    check("rst_occ", ifc.occupancy, 0);
    check("rst_wr_slot", ifc.wr_slot, 0);
    check("rst_host_slot", ifc.host_slot, 0);
    check("rst_drop", ifc.drop_cnt, 0);
    check("rst_state", state_dbg, ST_OFF);

    // first frame and gap length
    ifc.enable = 1'b1;
    step();
    check("arm_empty", ifc.rx_empty, 1);
    pulse_complete(12'd64, 32'h100);
    check("gap0_empty", ifc.rx_empty, 0);
    check("gap0_state", state_dbg, ST_GAP);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_low", ifc.rx_empty, 0);
    end
    step();
    check("gap_end_empty", ifc.rx_empty, 1);
    check("f1_valid", ifc.host_valid, 1);
    check("f1_len", ifc.host_len, 64);
    check("f1_ts", ifc.host_ts, 32'h100);
    check("f1_wr_slot", ifc.wr_slot, 1);
    check("f1_occ", ifc.occupancy, 1);

    // fill the ring
    pulse_complete(12'd100, 32'h200);
    wait_empty("fill2_arm");
    pulse_complete(12'd200, 32'h300);
    wait_empty("fill3_arm");
    pulse_complete(12'd300, 32'h400);
    step();
    step();
    step();
    step();
    check("full_state", state_dbg, ST_FULL);
    check("full_empty", ifc.rx_empty, 0);
    check("full_occ", ifc.occupancy, 4);
    pulse_complete(12'd999, 32'hDEAD);
    check("full_drop", ifc.drop_cnt, 1);
    check("full_len_kept", ifc.host_len, 64);
    check("full_occ_kept", ifc.occupancy, 4);
    check("full_wr_kept", ifc.wr_slot, 0);
    pulse_release();
    check("rel_occ", ifc.occupancy, 3);
    check("rel_host_slot", ifc.host_slot, 1);
    check("rel_len", ifc.host_len, 100);
    check("rel_still_full", state_dbg, ST_FULL);
    check("rel_empty_low", ifc.rx_empty, 0);
    step();
    check("rel_empty_high", ifc.rx_empty, 1);

    // simultaneous accept and release at occupancy 2
    pulse_release();
    check("sim_pre_occ", ifc.occupancy, 2);
    ifc.rx_complete  = 1'b1;
    ifc.rx_frame_len = 12'd400;
    ifc.rx_timestamp = 32'h500;
    ifc.host_release = 1'b1;
    step();
    ifc.rx_complete  = 1'b0;
    ifc.host_release = 1'b0;
    check("sim_occ", ifc.occupancy, 2);
    check("sim_host_slot", ifc.host_slot, 3);
    check("sim_wr_slot", ifc.wr_slot, 1);
    check("sim_state", state_dbg, ST_GAP);
    check("sim_len", ifc.host_len, 300);
    wait_empty("sim_arm");
    pulse_release();
    check("drain_len", ifc.host_len, 400);
    check("drain_ts", ifc.host_ts, 32'h500);
    pulse_release();
    check("drain_occ", ifc.occupancy, 0);
    check("drain_valid", ifc.host_valid, 0);

    // release when empty, drop during gap, enable drop in ARM
    pulse_release();
    check("nrel_occ", ifc.occupancy, 0);
    check("nrel_host_slot", ifc.host_slot, 1);
    check("nrel_state", state_dbg, ST_ARM);
    pulse_complete(12'd500, 32'h600);
    pulse_complete(12'd501, 32'h601);
    check("gapdrop_cnt", ifc.drop_cnt, 2);
    check("gapdrop_wr", ifc.wr_slot, 2);
    check("gapdrop_occ", ifc.occupancy, 1);
    check("gapdrop_len", ifc.host_len, 500);
    wait_empty("gapdrop_arm");
    pulse_release();
    ifc.enable = 1'b0;
    step();
    check("dis_empty", ifc.rx_empty, 0);
    check("dis_state", state_dbg, ST_OFF);
    ifc.enable = 1'b1;
    step();
    check("reen_empty", ifc.rx_empty, 1);

    // wrap through the ring with accept/release pairs
    apply_reset();
    check("rst2_state", state_dbg, ST_OFF);
    check("rst2_drop", ifc.drop_cnt, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("wrap_wr_slot", ifc.wr_slot, i % 4);
      exp_q.push_back({12'(16 * i + 5), 32'h1000 + 32'(i)});
      pulse_complete(12'(16 * i + 5), 32'h1000 + 32'(i));
      check("wrap_occ", ifc.occupancy, 1);
      exp_e = exp_q.pop_front();
      check("wrap_len", ifc.host_len, exp_e[43:32]);
      check("wrap_ts", ifc.host_ts, exp_e[31:0]);
      pulse_release();
      check("wrap_occ0", ifc.occupancy, 0);
      wait_empty("wrap_arm");
    end

    // asynchronous reset mid-gap at occupancy 3
    pulse_complete(12'd7, 32'h7);
    wait_empty("ar_fill1");
    pulse_complete(12'd8, 32'h8);
    wait_empty("ar_fill2");
    pulse_complete(12'd9, 32'h9);
    pulse_complete(12'd10, 32'hA);
    check("ar_pre_occ", ifc.occupancy, 3);
    check("ar_pre_drop", ifc.drop_cnt, 1);
    check("ar_pre_state", state_dbg, ST_GAP);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("ar_occ", ifc.occupancy, 0);
    check("ar_valid", ifc.host_valid, 0);
    check("ar_wr_slot", ifc.wr_slot, 0);
    check("ar_host_slot", ifc.host_slot, 0);
    check("ar_drop", ifc.drop_cnt, 0);
    check("ar_empty", ifc.rx_empty, 0);
    check("ar_state", state_dbg, ST_OFF);
    step();
    sys_rst_n = 1'b1;
    check("ar_post_state", state_dbg, ST_OFF);
    step();
    check("ar_post_arm", ifc.rx_empty, 1);
    check("ar_post_occ", ifc.occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
